sobel_line_buffer: RTL and testbench

Upstream neighbour of the 3x3 Sobel pixel buffer in the finger-vein pipeline. Accepts a raster-order grayscale pixel stream (one pixel per cycle max, gaps allowed), stores the two previous image rows in line memories, and emits, per accepted pixel, the vertically aligned column triple D1/D2/D3 (rows y-2, y-1, y). It also tracks frame position and flags the last output of a frame so the downstream window stage and FSM know where the frame ends.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_line_buffer_line_ram.sv | 23 ++
 rtl/sobel_line_buffer.sv | 117 +++++++++++
 tb/tb_sobel_line_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: default geometry, line-buffer
// FSM states and the zero-extended output pixel type used downstream.
package sobel_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned IMG_WIDTH  = 180;
  localparam int unsigned IMG_HEIGHT = 120;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  typedef logic [PIX_W:0] pix_t;

endpackage

// File: rtl/sobel_line_buffer_line_ram.sv
// One image row of storage: single port, combinational read of the addressed
// word in the same cycle it is overwritten (read-first).
module line_ram #(
  parameter int unsigned DEPTH = 180,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer emitting the vertical column triple (y-2, y-1, y) per pixel.
// Optional feature macro: LB_ZERO_PAD_EN (also emit rows 0..1 with missing rows zeroed).
module sobel_line_buffer #(
  parameter int unsigned IMG_WIDTH  = sobel_pkg::IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = sobel_pkg::IMG_HEIGHT,
  parameter int unsigned PIX_W      = sobel_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  output logic [PIX_W:0]   D1,
  output logic [PIX_W:0]   D2,
  output logic [PIX_W:0]   D3,
  output logic [7:0]       out_col,
  output logic [7:0]       out_row,
  output logic             frame_done
);

  import sobel_pkg::*;

  localparam int unsigned AW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
`ifdef LB_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic w_accept, w_emit, w_last;
  logic [PIX_W-1:0] w_l1_rd, w_l2_rd, w_d1, w_d2;

  // A sof pixel always lands at (0,0), regardless of where the counters were.
  always_comb begin
    w_accept    = in_valid && ((r_state != IDLE) || in_sof);
    w_col       = in_sof ? '0 : r_col;
    w_row       = in_sof ? '0 : r_row;
    w_last      = (w_row == ROW_LAST) && (w_col == COL_LAST);
    w_emit      = w_accept && (ZERO_PAD || ((r_state == RUN) && !in_sof));
    w_d1        = (w_row < RW'(2)) ? '0 : w_l1_rd;
    w_d2        = (w_row == '0)    ? '0 : w_l2_rd;
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (w_accept) begin
      if (w_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = w_last ? '0 : w_row + 1'b1;
      end else begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
      end
      if (in_sof) begin
        w_state_nxt = FILL;
      end else begin
        case (r_state)
          FILL:    if ((w_row == RW'(1)) && (w_col == COL_LAST)) w_state_nxt = RUN;
          RUN:     if (w_last) w_state_nxt = IDLE;
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      D1         <= '0;
      D2         <= '0;
      D3         <= '0;
      out_col    <= '0;
      out_row    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      out_valid  <= w_emit;
      frame_done <= w_emit && w_last;
      if (w_emit) begin
        D1      <= {1'b0, w_d1};
        D2      <= {1'b0, w_d2};
        D3      <= {1'b0, in_pix};
        out_col <= 8'(w_col);
        out_row <= 8'(w_row);
      end
    end
  end

  // line1 holds row y-2 and is refilled from line2 (row y-1) as it is read.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(AW)) u_line1 (
    .i_clk   (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (w_l2_rd),
    .o_rdata (w_l1_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(AW)) u_line2 (
    .i_clk   (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (in_pix),
    .o_rdata (w_l2_rd)
  );

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Bench for sobel_line_buffer on a 4x4 image; reference model stores whole
// frames and derives each column triple from absolute (row, col) positions.
module tb_sobel_line_buffer;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
`ifdef LB_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int OUTS = PAD ? W * H : (H - 2) * W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pix = '0;
  logic       out_valid, frame_done;
  pix_t       D1, D2, D3;
  logic [7:0] out_col, out_row;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sobel_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pix     (in_pix),
    .out_valid  (out_valid),
    .D1         (D1),
    .D2         (D2),
    .D3         (D3),
    .out_col    (out_col),
    .out_row    (out_row),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic       v;
    pix_t       d1, d2, d3;
    logic [7:0] row, col;
    logic       done;
  } obs_t;

  // Model: the frame as a 2D picture plus the raster position of the next pixel.
  logic [7:0] fm [H][W];
  bit         m_act = 1'b0;
  int         m_r = 0, m_c = 0;
  obs_t       ref_seq[$];

  task automatic model_step(input bit v, input bit sof, input logic [7:0] pix, output obs_t e);
    e = '0;
    if (v && (m_act || sof)) begin
      if (sof) begin
        m_act = 1'b1; m_r = 0; m_c = 0;
      end
      fm[m_r][m_c] = pix;
      if (m_r >= 2 || PAD) begin
        e.v    = 1'b1;
        e.d1   = (m_r >= 2) ? {1'b0, fm[m_r-2][m_c]} : '0;
        e.d2   = (m_r >= 1) ? {1'b0, fm[m_r-1][m_c]} : '0;
        e.d3   = {1'b0, pix};
        e.row  = 8'(m_r);
        e.col  = 8'(m_c);
        e.done = (m_r == H - 1) && (m_c == W - 1);
      end
      m_c++;
      if (m_c == W) begin
        m_c = 0; m_r++;
        if (m_r == H) begin
          m_r = 0; m_act = 1'b0;
        end
      end
    end
  endtask

  function automatic obs_t observe();
    obs_t o = '0;
    o.v    = out_valid;
    o.done = frame_done;
    if (out_valid === 1'b1) begin
      o.d1 = D1; o.d2 = D2; o.d3 = D3; o.row = out_row; o.col = out_col;
    end
    return o;
  endfunction

  task automatic apply(input bit v, input bit sof, input logic [7:0] pix, output obs_t e);
    in_valid = v; in_sof = sof; in_pix = pix;
    model_step(v, sof, pix, e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, frame_done, out_row, out_col} !== '0) begin
      n_err++; $display("FAIL reset_ctrl: got %b/%b/%h/%h want 0", out_valid, frame_done, out_row, out_col);
    end
    n_vec++;
    if ({D1, D2, D3} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h want 0", D1, D2, D3);
    end
    rst = 1'b0; m_act = 1'b0;
    apply(1'b0, 1'b0, 8'h00, e);
  endtask

  task automatic test_continuous();
    obs_t e;
    logic [7:0] p;
    int n = 0;
    ref_seq.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        p = 8'(r * 16 + c);
        apply(1'b1, (r == 0 && c == 0), p, e);
        n_vec++;
        if (observe() !== e) begin
          n_err++; $display("FAIL cont_stream: got %h want %h", observe(), e);
        end
        if (e.v) ref_seq.push_back(e);
        if (out_valid === 1'b1) n++;
        if (p == 8'h20) begin
          n_vec++;
          if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL first_out: out_valid %b want 1", out_valid);
          end
        end
        if (p == 8'h21) begin
          n_vec++;
          if ({D1, D2, D3, out_row, out_col} !== {9'h001, 9'h011, 9'h021, 8'd2, 8'd1}) begin
            n_err++; $display("FAIL pix21: got %h %h %h r%0d c%0d want 01 11 21 r2 c1", D1, D2, D3, out_row, out_col);
          end
        end
        if (p == 8'h02 && out_valid === 1'b1) begin
          n_vec++;
          if ({D1, D2, D3} !== {9'h000, 9'h000, 9'h002}) begin
            n_err++; $display("FAIL pad_row0: got %h %h %h want 00 00 02", D1, D2, D3);
          end
        end
        if (p == 8'h13 && out_valid === 1'b1) begin
          n_vec++;
          if ({D1, D2, D3} !== {9'h000, 9'h003, 9'h013}) begin
            n_err++; $display("FAIL pad_row1: got %h %h %h want 00 03 13", D1, D2, D3);
          end
        end
      end
    end
    apply(1'b0, 1'b0, 8'h00, e);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL cont_idle: out_valid %b want 0", out_valid);
    end
    n_vec++;
    if (n !== OUTS) begin
      n_err++; $display("FAIL cont_count: got %0d want %0d", n, OUTS);
    end
  endtask

  task automatic test_gaps();
    obs_t e;
    obs_t got[$];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while ($urandom % 2 == 1) begin
          apply(1'b0, 1'b0, 8'($urandom), e);
          n_vec++;
          if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL gap_idle: out_valid %b want 0", out_valid);
          end
        end
        apply(1'b1, (r == 0 && c == 0), 8'(r * 16 + c), e);
        n_vec++;
        if (observe() !== e) begin
          n_err++; $display("FAIL gap_stream: got %h want %h", observe(), e);
        end
        if (out_valid === 1'b1) got.push_back(observe());
      end
    end
    apply(1'b0, 1'b0, 8'h00, e);
    n_vec++;
    if (got.size() !== ref_seq.size()) begin
      n_err++; $display("FAIL gap_count: got %0d want %0d", got.size(), ref_seq.size());
    end else begin
      foreach (got[i]) begin
        n_vec++;
        if (got[i] !== ref_seq[i]) begin
          n_err++; $display("FAIL gap_seq[%0d]: got %h want %h", i, got[i], ref_seq[i]);
        end
      end
    end
  endtask

  task automatic test_frame_done();
    obs_t e;
    int n_done = 0;
    pix_t d3_at = '0;
    for (int i = 0; i < W * H; i++) begin
      apply(1'b1, (i == 0), 8'((i / W) * 16 + (i % W)), e);
      n_vec++;
      if (observe() !== e) begin
        n_err++; $display("FAIL fd_stream: got %h want %h", observe(), e);
      end
      if (frame_done === 1'b1) begin
        n_done++; d3_at = D3;
      end
    end
    n_vec++;
    if (n_done !== 1 || d3_at !== 9'h033) begin
      n_err++; $display("FAIL frame_done: pulses %0d D3 %h want 1 and 033", n_done, d3_at);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 8'h55, e);
      n_vec++;
      if ({out_valid, frame_done} !== 2'b00) begin
        n_err++; $display("FAIL post_frame_ignore: out_valid %b frame_done %b want 0 0", out_valid, frame_done);
      end
    end
  endtask

  task automatic test_mid_sof();
    obs_t e;
    logic [7:0] p;
    for (int i = 0; i < 2 * W + 1; i++) begin
      apply(1'b1, (i == 0), 8'((i / W) * 16 + (i % W)), e);
      n_vec++;
      if (observe() !== e) begin
        n_err++; $display("FAIL msof_old: got %h want %h", observe(), e);
      end
    end
    for (int i = 0; i < W * H; i++) begin
      p = 8'((i / W) * 16 + (i % W) + 8'h80);
      apply(1'b1, (i == 0), p, e);
      n_vec++;
      if (observe() !== e) begin
        n_err++; $display("FAIL msof_new: got %h want %h", observe(), e);
      end
      if (p == 8'hA0) begin
        n_vec++;
        if ({out_valid, D1, D2, D3, out_row, out_col} !== {1'b1, 9'h080, 9'h090, 9'h0A0, 8'd2, 8'd0}) begin
          n_err++; $display("FAIL msof_first: got v%b %h %h %h r%0d c%0d want v1 80 90 a0 r2 c0",
                            out_valid, D1, D2, D3, out_row, out_col);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    obs_t e;
    int first = -1;
    for (int i = 0; i < 2 * W + 2; i++) begin
      apply(1'b1, (i == 0), 8'((i / W) * 16 + (i % W)), e);
    end
    in_valid = 1'b0; in_sof = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, frame_done, D1, D2, D3, out_row, out_col} !== '0) begin
      n_err++; $display("FAIL rst_async: got v%b fd%b %h %h %h r%0d c%0d want all 0",
                        out_valid, frame_done, D1, D2, D3, out_row, out_col);
    end
    m_act = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 8'($urandom), e);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_nosof: out_valid %b want 0", out_valid);
      end
    end
    for (int i = 0; i < W * H; i++) begin
      apply(1'b1, (i == 0), 8'($urandom), e);
      n_vec++;
      if (observe() !== e) begin
        n_err++; $display("FAIL rst_stream: got %h want %h", observe(), e);
      end
      if (out_valid === 1'b1 && first < 0) first = i;
    end
    n_vec++;
    if (first !== (PAD ? 0 : 2 * W)) begin
      n_err++; $display("FAIL rst_resume: first output at %0d want %0d", first, PAD ? 0 : 2 * W);
    end
  endtask

  task automatic test_random();
    obs_t e;
    bit v, sof;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom % 2) == 1;
      sof = v && (m_act ? ($urandom % 50 == 0) : ($urandom % 4 != 0));
      apply(v, sof, 8'($urandom), e);
      n_vec++;
      if (observe() !== e) begin
        n_err++; $display("FAIL rand_stream[%0d]: got %h want %h", i, observe(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_frame_done();
    test_mid_sof();
    test_rst_mid();
    test_random();
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
